// File: rtl/relm_code_loader_if.sv
// relm_code_loader_if: push-channel input and op-write/status outputs of the ReLM code loader.
interface relm_code_loader_if #(
    parameter int WID = 2,
    parameter int WAD = 8,
    parameter int WD  = 32,
    parameter int WOP = 5
);
    logic [WD:0]          push_d;
    logic                 push_retry;
    logic                 op_we_out;
    logic [WAD+WID-1:0]   op_wa_out;
    logic [WOP-1:0]       op_d_out;
    logic                 busy_out;
    logic                 done_out;
    logic                 err_out;
    modport master (output push_d, input push_retry, op_we_out, op_wa_out, op_d_out, busy_out, done_out, err_out);
    modport slave (input push_d, output push_retry, op_we_out, op_wa_out, op_d_out, busy_out, done_out, err_out);
endinterface

// File: rtl/relm_code_loader.sv
// relm_code_loader: decodes ADDR/COUNT/payload/CHECK frames from a push channel into op-memory writes.
module relm_code_loader #(
    parameter int WID = 2,
    parameter int WAD = 8,
    parameter int WD  = 32,
    parameter int WOP = 5
) (
    input  logic                clk,
    input  logic                reset_in,
    relm_code_loader_if.slave   bus
);
    localparam int WA = WAD + WID;
    typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;
    state_t           r_state, w_state;
    logic [WA-1:0]    r_addr, w_addr, r_wa, w_wa;
    logic [WA:0]      r_cnt, w_cnt;
    logic [WD-2:0]    r_sum, w_sum;
    logic [WOP-1:0]   r_d, w_d;
    logic             r_we, w_we, r_busy, r_done, w_done, r_err, w_err;
    logic             w_acc;
    logic [WD-1:0]    w_word;
    logic [WD-2:0]    w_s;
    assign w_acc  = bus.push_d[WD];
    assign w_word = bus.push_d[WD-1:0];
    assign w_s    = w_word[WD-2:0];
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_cnt   = r_cnt;
        w_sum   = r_sum;
        w_we    = 1'b0;
        w_wa    = r_wa;
        w_d     = r_d;
        w_done  = 1'b0;
        w_err   = r_err;
        // An abort word only means something mid-frame; in IDLE it is a resync marker.
        if (w_acc && w_word[WD-1]) begin
            if (r_state != IDLE) begin
                w_state = IDLE;
                w_err   = 1'b1;
            end
        end else if (w_acc) begin
            case (r_state)
                IDLE: begin
                    w_addr  = w_word[WA-1:0];
                    w_sum   = w_s;
                    w_err   = 1'b0;
                    w_state = COUNT;
                end
                COUNT: begin
                    w_cnt   = w_word[WA:0];
                    w_sum   = r_sum ^ w_s;
                    w_state = |w_word[WA:0] ? DATA : CHECK;
                end
                DATA: begin
                    w_we    = 1'b1;
                    w_wa    = r_addr;
                    w_d     = w_word[WOP-1:0];
                    w_sum   = r_sum ^ w_s;
                    w_addr  = r_addr + WA'(1);
                    w_cnt   = r_cnt - (WA+1)'(1);
                    w_state = (r_cnt == (WA+1)'(1)) ? CHECK : DATA;
                end
                default: begin
                    w_done  = (w_s == r_sum);
                    w_err   = r_err | (w_s != r_sum);
                    w_state = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_cnt   <= w_cnt;
            r_sum   <= w_sum;
            r_we    <= w_we;
            r_wa    <= w_wa;
            r_d     <= w_d;
            r_busy  <= (w_state != IDLE);
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end
    assign bus.push_retry = reset_in;
    assign bus.op_we_out  = r_we;
    assign bus.op_wa_out  = r_wa;
    assign bus.op_d_out   = r_d;
    assign bus.busy_out   = r_busy;
    assign bus.done_out   = r_done;
    assign bus.err_out    = r_err;
endmodule

// File: tb/tb_relm_code_loader.sv
// tb_relm_code_loader: table-driven frames plus abort/reset sequences, writes checked through a scoreboard queue.
module tb_relm_code_loader;
    logic clk = 1'b0;
    logic reset_in = 1'b1;
    relm_code_loader_if #(.WID(2), .WAD(8), .WD(32), .WOP(5)) bus ();
    relm_code_loader #(.WID(2), .WAD(8), .WD(32), .WOP(5)) dut (.clk(clk), .reset_in(reset_in), .bus(bus.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       cnt;
        logic [3:0][31:0]  ops;
        logic [31:0]       chk;
        int                gap;
        bit                exp_done;
        bit                exp_err;
    } vec_t;

    int checks = 0, failures = 0;
    int n_wr = 0, n_done = 0, cyc = 0, first_wr = -1, last_wr = -1;
    logic [14:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write the DUT presents must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.done_out) n_done++;
        if (bus.op_we_out) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (q.size() == 0) chk("unexpected_write", {17'd0, bus.op_wa_out, bus.op_d_out}, 32'h7fff_ffff);
            else chk("write_wa_d", {17'd0, bus.op_wa_out, bus.op_d_out}, {17'd0, q.pop_front()});
        end
    end

    task automatic send(input logic [31:0] w, input int g);
        @(negedge clk) bus.push_d = {1'b1, w};
        repeat (g) @(negedge clk) bus.push_d = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk) bus.push_d = '0;
    endtask

    function automatic int gap_of(input int g);
        return (g < 0) ? int'($urandom_range(0, 3)) : g;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int d0, w0;
        logic [9:0] wa;
        d0 = n_done;
        w0 = n_wr;
        first_wr = -1;
        for (int i = 0; i < int'(v.cnt); i++) begin
            wa = 10'((v.addr + 32'(i)) % 1024);
            q.push_back({wa, v.ops[i][4:0]});
        end
        send(v.addr, gap_of(v.gap));
        send(v.cnt, gap_of(v.gap));
        for (int i = 0; i < int'(v.cnt); i++) send(v.ops[i], gap_of(v.gap));
        send(v.chk, gap_of(v.gap));
        idle(3);
        chk({tag, "_done"}, 32'(n_done - d0), {31'd0, v.exp_done});
        chk({tag, "_err"}, {31'd0, bus.err_out}, {31'd0, v.exp_err});
        chk({tag, "_busy"}, {31'd0, bus.busy_out}, 32'd0);
        chk({tag, "_nwr"}, 32'(n_wr - w0), v.cnt);
        chk({tag, "_qempty"}, 32'(q.size()), 32'd0);
        if (v.gap == 0 && v.cnt > 1) chk({tag, "_nobubble"}, 32'(last_wr - first_wr), v.cnt - 1);
    endtask

    vec_t vecs[5];

    initial begin
        vec_t basic;
        int w0, d0;
        basic = '{addr: 32'h004, cnt: 32'd3, ops: {32'h0, 32'h08, 32'h1F, 32'h01}, chk: 32'h011, gap: 0, exp_done: 1, exp_err: 0};
        vecs[0] = basic;
        vecs[1] = '{addr: 32'h3FF, cnt: 32'd2, ops: {32'h0, 32'h0, 32'h03, 32'h02}, chk: 32'h3FC, gap: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{addr: 32'h010, cnt: 32'd0, ops: '0, chk: 32'h010, gap: -1, exp_done: 1, exp_err: 0};
        vecs[3] = '{addr: 32'h004, cnt: 32'd3, ops: {32'h0, 32'h08, 32'h1F, 32'h01}, chk: 32'h012, gap: 0, exp_done: 0, exp_err: 1};
        vecs[4] = '{addr: 32'h100, cnt: 32'd1, ops: {32'h0, 32'h0, 32'h0, 32'h0FF5}, chk: 32'hEF4, gap: 1, exp_done: 1, exp_err: 0};

        bus.push_d = {1'b1, 32'h123};
        repeat (3) @(negedge clk);
        chk("rst_retry", {31'd0, bus.push_retry}, 32'd1);
        chk("rst_outputs", {22'd0, bus.op_we_out, bus.op_wa_out, bus.op_d_out, bus.busy_out, bus.done_out, bus.err_out}, 32'd0);
        reset_in = 1'b0;
        bus.push_d = '0;
        idle(2);
        chk("idle_retry", {31'd0, bus.push_retry}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy_out}, 32'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Bad checksum leaves err set until the next ADDR word is accepted.
        run_frame(vecs[3], "bad2");
        send(32'h200, 0);
        idle(1);
        chk("errclr_on_addr", {31'd0, bus.err_out}, 32'd0);
        chk("busy_after_addr", {31'd0, bus.busy_out}, 32'd1);
        d0 = n_done;
        send(32'd0, 0);
        send(32'h200, 0);
        idle(3);
        chk("errclr_frame_done", 32'(n_done - d0), 32'd1);

        // Abort after the first payload word.
        w0 = n_wr;
        d0 = n_done;
        q.push_back({10'h020, 5'h07});
        send(32'h020, 0);
        send(32'd3, 0);
        send(32'h07, 0);
        send(32'h8000_0000, 0);
        idle(3);
        chk("abort_nwr", 32'(n_wr - w0), 32'd1);
        chk("abort_err", {31'd0, bus.err_out}, 32'd1);
        chk("abort_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("abort_nodone", 32'(n_done - d0), 32'd0);
        send(32'h8000_0000, 1);
        send(32'h8000_0000, 0);
        idle(1);
        chk("idle_abort_busy", {31'd0, bus.busy_out}, 32'd0);
        run_frame(basic, "after_abort");

        // Reset in the middle of DATA drops the frame.
        q.push_back({10'h040, 5'h09});
        q.push_back({10'h041, 5'h0A});
        send(32'h040, 0);
        send(32'd4, 0);
        send(32'h09, 0);
        send(32'h0A, 0);
        @(negedge clk);
        reset_in = 1'b1;
        bus.push_d = {1'b1, 32'h0B};
        w0 = n_wr;
        @(negedge clk);
        chk("midrst_retry", {31'd0, bus.push_retry}, 32'd1);
        chk("midrst_outputs", {22'd0, bus.op_we_out, bus.op_wa_out, bus.op_d_out, bus.busy_out, bus.done_out, bus.err_out}, 32'd0);
        reset_in = 1'b0;
        bus.push_d = '0;
        idle(5);
        chk("midrst_nowr", 32'(n_wr - w0), 32'd0);
        chk("midrst_err", {31'd0, bus.err_out}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy_out}, 32'd0);
        run_frame(vecs[1], "after_reset");

        chk("final_qempty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/relm_code_loader.md
# relm_code_loader

Boot/reload sequencer for the ReLM op-code memory. It receives a framed word stream on a push channel driven by a host PE's push port or a FIFO. It decodes a header (start address, count), writes each payload op-code through the ring's shared `op_we_in/op_wa_in/op_d_in` write port, and validates a trailing XOR checksum. It sits between a push-channel source and the op-write inputs of the `relm` top.

## Interface
Parameters:
- `WID`, 2, log2 of PE count; op address low bits select the PE.
- `WAD`, 8, per-PE code address width.
- `WD`, 32, stream word width; must satisfy WD ≥ WAD+WID+2.
- `WOP`, 5, op-code width; WOP < WD-1.

Ports:
- `clk`  in  1  clock; single clock domain.
- `reset_in`  in  1  synchronous, active-high reset.
- `push_d`  in  WD+1  push channel; bit WD = strobe, [WD-1:0] = word.
- `push_retry`  out  1  back-pressure to the source; equals `reset_in` (combinational), otherwise 0.
- `op_we_out`  out  1  op-memory write enable, one cycle per op.
- `op_wa_out`  out  WAD+WID  op-memory write address.
- `op_d_out`  out  WOP  op-code to write.
- `busy_out`  out  1  high while in any state other than IDLE.
- `done_out`  out  1  one-cycle pulse when the frame ends with a checksum match.
- `err_out`  out  1  sticky error; cleared when the next frame's address header is accepted.

## Operation
- Frame format: ADDR word, then COUNT word, then COUNT payload words, then a CHECK word.
- Word accept: `push_d[WD]=1` at a rising edge while `reset_in=0`.
- ABORT word: an accepted word with bit WD-1 set, in any non-IDLE state.
  - State returns to IDLE.
  - `err_out` is set to 1.
  - No write occurs and no `done_out` pulse is produced.
  - In IDLE, such a word is ignored (resync marker).
- States:
  - IDLE:
    - Accepted word (bit WD-1 = 0) loads `addr = word[WAD+WID-1:0]`.
    - Seeds `sum = word[WD-2:0]`.
    - Clears `err_out`.
    - Goes to COUNT.
  - COUNT:
    - Loads `cnt = word[WAD+WID:0]`, a range of 0..2^(WAD+WID).
    - Sets `sum ^= word[WD-2:0]`.
    - Goes to DATA if cnt ≠ 0, else CHECK.
  - DATA, per accepted word:
    - Writes `op_d = word[WOP-1:0]` at `addr`.
    - Sets `sum ^= word[WD-2:0]`.
    - `addr` increments modulo 2^(WAD+WID), wrapping to 0.
    - `cnt` decrements; on reaching 0, goes to CHECK.
  - CHECK:
    - If `word[WD-2:0] == sum`, pulses `done_out`.
    - Otherwise sets `err_out`.
    - Goes to IDLE.
- `push_d` words without the strobe bit are ignored in every state. Arbitrary gaps between words are allowed.
- Address-to-PE mapping follows the ring convention: `op_wa_out[WID-1:0]` = PE id, `op_wa_out[WID+:WAD]` = code address.
- Bits of a payload word above WOP-1 enter the checksum but are not written.
- The loader does not halt the ring. The host software must park the PEs whose code is being replaced.

## Timing
- Reset (synchronous): state IDLE; `op_we_out`, `op_wa_out`, `op_d_out`, `busy_out`, `done_out`, `err_out`, `addr`, `cnt` and `sum` are all 0.
- Reset mid-frame discards the frame with no further writes and leaves `err_out` = 0.
- All outputs except `push_retry` are registered.
- Payload write latency: for a word accepted at edge t, `op_we_out`, `op_wa_out` and `op_d_out` are valid in the cycle after edge t. The relm op memory commits the write at edge t+1.
- Back-to-back payload words, one per cycle, give one write per cycle with no bubbles. Throughput is 1 word per cycle with no back-pressure.
- `op_we_out` is low in every cycle that does not follow an accepted DATA word.
- `done_out` is high for exactly the cycle after the accepting edge of the CHECK word.
- `err_out` rises in the cycle after the accepting edge of a bad CHECK word or an ABORT word.
- `busy_out` rises the cycle after ADDR is accepted. It falls the cycle after CHECK is accepted or an abort occurs.

## Test plan
- Basic frame (WID=2, WAD=8): ADDR=0x004, COUNT=3, ops 0x01, 0x1F, 0x08, CHECK = 0x004^3^0x01^0x1F^0x08 = 0x011. Required response:
  - Writes (wa, d) = (0x004, 0x01), (0x005, 0x1F), (0x006, 0x08) on three consecutive cycles.
  - `done_out` pulses once; `err_out` = 0.
- Wrap-around: ADDR=0x3FF, COUNT=2, ops 0x02, 0x03, correct CHECK. Required: writes at 0x3FF then 0x000, then `done_out`.
- Gapped stream with COUNT=0: words separated by 0–3 idle cycles; ADDR=0x010, COUNT=0, CHECK=0x010. Required: no writes, `done_out` pulses, `busy_out` falls.
- Bad checksum: basic frame with CHECK=0x012. Required:
  - All 3 writes still occur, `done_out` stays 0 and `err_out` = 1.
  - `err_out` clears on the next accepted ADDR.
- Abort and reset:
  - An ABORT word (0x80000000) after the 1st payload word gives 1 write, then IDLE with `err_out` = 1.
  - A following frame with ABORT words in IDLE still loads correctly.
  - `reset_in` asserted mid-DATA gives no further writes, all outputs 0, and `push_retry` = 1 during reset.
